uart_rx_core: RTL and testbench

- User-project UART receiver: deserialises the 8N1 stream driven onto mprj_io[5] by the bench UART (or an external host) into bytes.
- Received bytes are buffered in a small FIFO and presented on a valid/ready interface to the Wishbone register wrapper, which firmware polls or takes an interrupt from.
- Detects framing errors and overrun.
- Sits directly downstream of the serial line and upstream of the CPU-visible UART registers.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 tb/tb_uart_rx_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  localparam int DATA_BITS       = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int MIN_DIV_DEFAULT = 8;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO whose head entry is held in its own register, so the
// read data is stable, resettable and valid the cycle after a push into an empty FIFO.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   count_q;
  logic [W-1:0]  head_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign rdata_o = head_q;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_next;
        if (count_q == (AW+1)'(1)) begin
          if (do_push) head_q <= wdata_i;
        end else begin
          head_q <= mem_q[rd_next];
        end
      end else if (empty_o && do_push) begin
        head_q <= wdata_i;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, 3-sample majority filter, bit-timing FSM,
// sticky framing/overrun flags and a receive FIFO with a valid/ready pop side.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = MIN_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   rx_en,
  input  logic [DIV_W-1:0]       clk_div,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   err_clr,
  output logic                   irq
);

  state_e                       state_q;
  logic [SYNC_STAGES-1:0]       sync_q;
  logic [2:0]                   samp_q;
  logic [DIV_W-1:0]             cnt_q, d_eff, half;
  logic [$clog2(DATA_BITS)-1:0] bit_idx_q;
  logic [DATA_BITS-1:0]         shift_q;
  logic                         busy_q, frame_err_q, overrun_q;
  logic                         rx_s, bit_val, fall, cnt_zero, stop_done;
  logic                         push, pop, fifo_full, fifo_empty, frame_evt, ovr_evt;

  assign d_eff     = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign half      = d_eff >> 1;
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign bit_val   = maj3(samp_q);
  // samp_q[0] holds the previous synchronised sample.
  assign fall      = samp_q[0] & ~rx_s;
  assign cnt_zero  = (cnt_q == '0);
  assign stop_done = rx_en && (state_q == STOP) && cnt_zero;
  assign push      = stop_done & bit_val;
  assign frame_evt = stop_done & ~bit_val;
  assign pop       = rx_valid & rx_ready;
  assign ovr_evt   = push & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      samp_q      <= '1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      samp_q <= {samp_q[1:0], rx_s};
      if (!rx_en) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (fall) begin
            state_q <= START;
            cnt_q   <= half - 1'b1;
            busy_q  <= 1'b1;
          end
          START: if (cnt_zero) begin
            if (!bit_val) begin
              state_q   <= DATA;
              cnt_q     <= d_eff - 1'b1;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else cnt_q <= cnt_q - 1'b1;
          DATA: if (cnt_zero) begin
            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
            cnt_q   <= d_eff - 1'b1;
            if (bit_idx_q == ($clog2(DATA_BITS))'(DATA_BITS-1)) state_q <= STOP;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
          STOP: if (cnt_zero) begin
            if (bit_val) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_IDLE;
            end
          end else cnt_q <= cnt_q - 1'b1;
          WAIT_IDLE: if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
      // Clear first so a same-cycle error event wins.
      if (err_clr) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (frame_evt) frame_err_q <= 1'b1;
      if (ovr_evt)   overrun_q   <= 1'b1;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH), .W(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rx_valid  = ~fifo_empty;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign irq       = rx_valid | frame_err_q | overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus random frames checked
// against a byte-level queue model of the receive FIFO and sticky flags.
module tb_uart_rx_core;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, rx, rx_en, rx_ready, err_clr;
  logic [DIV_W-1:0] clk_div;
  logic [7:0]       rx_data;
  logic             rx_valid, busy, frame_err, overrun, irq;
  logic [CW-1:0]    fifo_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       exp_fe, exp_ov;

  uart_rx_core #(.DEPTH(DEPTH), .DIV_W(DIV_W), .MIN_DIV(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_en      (rx_en),
    .clk_div    (clk_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one whole 8N1 frame, bit period bitc cycles; line left at the stop level.
  task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input int bitc);
    rx = 1'b0;
    step(bitc);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      step(bitc);
    end
    rx = stop_lvl;
    step(bitc);
  endtask

  // ---------------- reference model ----------------
  task automatic model_rx_byte(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ov = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "/count"}, 32'(fifo_count), exp_q.size());
    check({tag, "/valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "/data"}, 32'(rx_data), 32'(exp_q[0]));
    check({tag, "/frame_err"}, 32'(frame_err), 32'(exp_fe));
    check({tag, "/overrun"}, 32'(overrun), 32'(exp_ov));
    check({tag, "/irq"}, 32'(irq), 32'((exp_q.size() != 0) | exp_fe | exp_ov));
  endtask

  task automatic pop_one(input string tag);
    check({tag, "/pop_data"}, 32'(rx_data), 32'(exp_q[0]));
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) pop_one(tag);
    check_status({tag, "/drained"});
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/rx_data"}, 32'(rx_data), 0);
    check({tag, "/rx_valid"}, 32'(rx_valid), 0);
    check({tag, "/count"}, 32'(fifo_count), 0);
    check({tag, "/busy"}, 32'(busy), 0);
    check({tag, "/frame_err"}, 32'(frame_err), 0);
    check({tag, "/overrun"}, 32'(overrun), 0);
    check({tag, "/irq"}, 32'(irq), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    logic prev_busy;
    logic [7:0] b;
    int d, nb;

    rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    clk_div = 16'd16;
    exp_fe = 1'b0; exp_ov = 1'b0;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(4);
    check_status("idle");

    // Single byte; watch the stop bit for the cycle the byte lands.
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = 8'h3D >> i;
      step(16);
    end
    check("b1/valid_before_stop", 32'(rx_valid), 0);
    check("b1/busy_before_stop", 32'(busy), 1);
    rx = 1'b1;
    lat = -1;
    prev_busy = busy;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      if (rx_valid) begin
        lat = c;
        check("b1/busy_prev_cycle", 32'(prev_busy), 1);
        check("b1/busy_at_valid", 32'(busy), 0);
      end
      prev_busy = busy;
    end
    check("b1/valid_within_stop_bit", 32'(lat >= 2 && lat <= 16), 1);
    step(16);
    model_rx_byte(8'h3D);
    check_status("b1");
    drain("b1");

    // Two back-to-back frames held in the FIFO.
    send_frame(8'h3D, 1'b1, 16);
    model_rx_byte(8'h3D);
    send_frame(8'h0A, 1'b1, 16);
    model_rx_byte(8'h0A);
    check_status("b2b");
    drain("b2b");

    // Bad stop bit followed by a long break.
    send_frame(8'h55, 1'b0, 16);
    exp_fe = 1'b1;
    step(40 * 16);
    check("break/busy_held", 32'(busy), 1);
    check_status("break");
    rx = 1'b1;
    step(6);
    check("break/busy_released", 32'(busy), 0);
    check_status("break_end");
    clear_errors();
    check_status("break_clr");

    // Five bytes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 16);
      model_rx_byte(8'(i));
    end
    check("ovr/overrun_expected", 32'(exp_ov), 1);
    check_status("ovr");
    drain("ovr");
    clear_errors();
    check_status("ovr_clr");

    // Short glitch on an idle line is a false start.
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    step(40);
    check("glitch/busy", 32'(busy), 0);
    check_status("glitch");

    // Disable mid-DATA with one byte already queued; pops still work.
    send_frame(8'hC3, 1'b1, 16);
    model_rx_byte(8'hC3);
    rx = 1'b0;
    step(16);
    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(16);
    check("en/busy_mid_data", 32'(busy), 1);
    rx_en = 1'b0;
    step(2);
    check("en/busy_after_disable", 32'(busy), 0);
    pop_one("en");
    rx = 1'b0;
    step(16 * 3);
    rx = 1'b1;
    step(16 * 4);
    rx_en = 1'b1;
    step(16);
    check("en/busy_reenabled", 32'(busy), 0);
    check_status("en");

    // Divisor below the floor is clamped to 8 clocks per bit.
    clk_div = 16'd3;
    step(4);
    send_frame(8'hA5, 1'b1, 8);
    model_rx_byte(8'hA5);
    check_status("clamp");

    // Reset in the middle of a frame, with a byte and a flag pending.
    exp_q.delete();
    clk_div = 16'd16;
    send_frame(8'h77, 1'b0, 16);
    rx = 1'b0;
    step(16 * 4);
    rst_n = 1'b0;
    step();
    check_all_zero("midreset");
    rx = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(8);
    exp_fe = 1'b0; exp_ov = 1'b0;
    check_status("after_reset");

    // Random divisors, bursts and data, drained after each burst.
    for (int it = 0; it < 6; it++) begin
      d  = $urandom_range(8, 24);
      nb = $urandom_range(1, 6);
      clk_div = DIV_W'(d);
      step(4);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, d);
        model_rx_byte(b);
        step($urandom_range(0, 3));
      end
      check_status($sformatf("rand%0d", it));
      drain($sformatf("rand%0d", it));
      clear_errors();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
